pipe_hazard_ctrl: RTL and testbench

//   Hazard and stall sequencer for the RV32IM 5-stage pipeline. Decides each

---
 rtl/pipe_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for the RV32IM 5-stage pipeline: load-use stalls, branch flush, mul/div sequencing.
// Optional perf counters are enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_wr,
  input  logic       ex_is_load,
  input  logic       ex_is_mul,
  input  logic       ex_is_div,
  input  logic       pcsrc,
  output logic       stall_pc,
  output logic       stall_ifid,
  output logic       flush_ifid,
  output logic       bubble_idex,
  output logic       hold_idex,
  output logic       md_start,
  output logic       md_busy,
`ifdef HAZ_PERF_CNT_EN
  output logic       md_done,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`else
  output logic       md_done
`endif
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0] MUL_M1  = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic             MUL_ONE = (MUL_LAT == 1);
  localparam logic             DIV_ONE = (DIV_LAT == 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             md;
  logic             lat_is_one;
  logic [CNT_W-1:0] lat_m1;
  logic             load_use;

  assign md         = ex_is_mul | ex_is_div;
  assign lat_is_one = ex_is_div ? DIV_ONE : MUL_ONE;
  assign lat_m1     = ex_is_div ? DIV_M1 : MUL_M1;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency
  assign load_use = ex_is_load && (ex_wr != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_wr)) ||
                     (id_use_rs2 && (id_rs2 == ex_wr)));

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    hold_idex   = 1'b0;
    md_start    = 1'b0;
    md_busy     = 1'b0;
    md_done     = 1'b0;

    // Outputs are forced low for the whole reset cycle, not just after it
    if (clrn) begin
      unique case (state_q)
        IDLE: begin
          if (pcsrc) begin
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
          end else if (md) begin
            md_start   = 1'b1;
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            hold_idex  = 1'b1;
            if (lat_is_one) begin
              state_d = DONE;
            end else begin
              state_d = BUSY;
              cnt_d   = lat_m1;
            end
          end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
          end
        end
        BUSY: begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          hold_idex  = 1'b1;
          md_busy    = 1'b1;
          cnt_d      = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = DONE;
          end
        end
        DONE: begin
          // EX advances on this edge; returning to IDLE prevents a restart of the retiring op
          md_done = 1'b1;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!clrn) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_pc) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (flush_ifid) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

  // A redirect while the mul/div op still occupies EX would be lost
  a_no_pcsrc_in_md: assert property (
    @(posedge clk) disable iff (!clrn) !(pcsrc && (state_q != IDLE))
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: table of single-cycle IDLE vectors plus mul/div/reset sequences.
// Perf counter checks are included when HAZ_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       clrn;
  logic [4:0] id_rs1, id_rs2, ex_wr;
  logic       id_use_rs1, id_use_rs2;
  logic       ex_is_load, ex_is_mul, ex_is_div, pcsrc;
  logic       stall_pc, stall_ifid, flush_ifid, bubble_idex, hold_idex;
  logic       md_start, md_busy, md_done;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_LAT(1), .DIV_LAT(32)) dut (
    .clk(clk), .clrn(clrn),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_wr(ex_wr), .ex_is_load(ex_is_load),
    .ex_is_mul(ex_is_mul), .ex_is_div(ex_is_div), .pcsrc(pcsrc),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
    .bubble_idex(bubble_idex), .hold_idex(hold_idex),
    .md_start(md_start), .md_busy(md_busy),
`ifdef HAZ_PERF_CNT_EN
    .md_done(md_done),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`else
    .md_done(md_done)
`endif
  );

  // {stall_pc, stall_ifid, flush_ifid, bubble_idex, hold_idex, md_start, md_busy, md_done}
  logic [7:0] outs;
  assign outs = {stall_pc, stall_ifid, flush_ifid, bubble_idex, hold_idex, md_start, md_busy, md_done};

  localparam logic [7:0] O_NONE  = 8'b0000_0000;
  localparam logic [7:0] O_LU    = 8'b1101_0000;
  localparam logic [7:0] O_FLUSH = 8'b0011_0000;
  localparam logic [7:0] O_START = 8'b1100_1100;
  localparam logic [7:0] O_BUSY  = 8'b1100_1010;
  localparam logic [7:0] O_DONE  = 8'b0000_0001;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, wr;
    logic       use1, use2, ld, mul, div, br;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(string n, logic [4:0] rs1, logic use1, logic [4:0] rs2, logic use2,
                              logic [4:0] wr, logic ld, logic mul, logic div, logic br, logic [7:0] exp);
    vec_t v;
    v.name = n; v.rs1 = rs1; v.use1 = use1; v.rs2 = rs2; v.use2 = use2;
    v.wr = wr; v.ld = ld; v.mul = mul; v.div = div; v.br = br; v.exp = exp;
    return v;
  endfunction

  task automatic check(string nm, logic [7:0] exp);
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL %s: outputs got %b expected %b (t=%0t)", nm, outs, exp, $time);
    end
  endtask

  task automatic check32(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_wr = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_is_load = 1'b0; ex_is_mul = 1'b0; ex_is_div = 1'b0; pcsrc = 1'b0;
  endtask

  // Caller is at a negedge; drives the op and checks every cycle through md_done and one idle cycle.
  task automatic run_md(string nm, int lat, bit div);
    logic [7:0] e;
    ex_is_div = div;
    ex_is_mul = !div;
    for (int c = 0; c <= lat; c++) begin
      #1;
      if (c == 0)        e = O_START;
      else if (c < lat)  e = O_BUSY;
      else               e = O_DONE;
      check($sformatf("%s_c%0d", nm, c), e);
      if (c == lat) begin
        ex_is_div = 1'b0;
        ex_is_mul = 1'b0;
      end
      @(negedge clk);
    end
    #1;
    check({nm, "_after"}, O_NONE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk("lu_rs1",     5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 0, 0, O_LU);
    vecs[1]  = mk("x0_rs2",     5'd0, 0, 5'd0, 1, 5'd0, 1, 0, 0, 0, O_NONE);
    vecs[2]  = mk("lu_rs2",     5'd3, 1, 5'd7, 1, 5'd7, 1, 0, 0, 0, O_LU);
    vecs[3]  = mk("no_use",     5'd5, 0, 5'd5, 0, 5'd5, 1, 0, 0, 0, O_NONE);
    vecs[4]  = mk("not_load",   5'd5, 1, 5'd0, 0, 5'd5, 0, 0, 0, 0, O_NONE);
    vecs[5]  = mk("diff_reg",   5'd4, 1, 5'd6, 1, 5'd5, 1, 0, 0, 0, O_NONE);
    vecs[6]  = mk("x0_rs1",     5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0, 0, O_NONE);
    vecs[7]  = mk("pcsrc_lu",   5'd9, 1, 5'd0, 0, 5'd9, 1, 0, 0, 1, O_FLUSH);
    vecs[8]  = mk("pcsrc_only", 5'd1, 1, 5'd2, 1, 5'd3, 0, 0, 0, 1, O_FLUSH);
    vecs[9]  = mk("mul_start",  5'd0, 0, 5'd0, 0, 5'd8, 0, 1, 0, 0, O_START);
    vecs[10] = mk("div_start",  5'd0, 0, 5'd0, 0, 5'd8, 0, 0, 1, 0, O_START);
    vecs[11] = mk("md_over_lu", 5'd8, 1, 5'd0, 0, 5'd8, 1, 1, 0, 0, O_START);
    vecs[12] = mk("pcsrc_md",   5'd0, 0, 5'd0, 0, 5'd8, 0, 1, 1, 1, O_FLUSH);

    // Reset with a live load-use hazard on the inputs: outputs must stay low
    clrn = 1'b0;
    clear_inputs();
    ex_is_load = 1'b1; ex_wr = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_outputs", O_NONE);
`ifdef HAZ_PERF_CNT_EN
    check32("reset_perf_stall", perf_stall_cnt, 32'd0);
    check32("reset_perf_flush", perf_flush_cnt, 32'd0);
`endif
    clear_inputs();
    clrn = 1'b1;
    @(negedge clk);
    #1;
    check("idle_after_reset", O_NONE);

    // Table vectors: driven and removed between clock edges so the FSM stays in IDLE
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      id_rs1 = vecs[i].rs1; id_use_rs1 = vecs[i].use1;
      id_rs2 = vecs[i].rs2; id_use_rs2 = vecs[i].use2;
      ex_wr = vecs[i].wr; ex_is_load = vecs[i].ld;
      ex_is_mul = vecs[i].mul; ex_is_div = vecs[i].div; pcsrc = vecs[i].br;
      #1;
      check(vecs[i].name, vecs[i].exp);
      #1;
      clear_inputs();
    end

    // Load-use stalls exactly one cycle once EX holds the bubble
    @(negedge clk);
    ex_is_load = 1'b1; ex_wr = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    #1;
    check("lu_seq_c0", O_LU);
    @(negedge clk);
    clear_inputs();
    #1;
    check("lu_seq_c1", O_NONE);

    // MUL with latency 1
    @(negedge clk);
    run_md("mul", 1, 1'b0);

    // Full 32-cycle divide
    @(negedge clk);
`ifdef HAZ_PERF_CNT_EN
    check32("perf_stall_pre_div", perf_stall_cnt, 32'd2);
    check32("perf_flush_pre_div", perf_flush_cnt, 32'd0);
`endif
    run_md("div", 32, 1'b1);

    // Reset in cycle 10 of a divide aborts it
    @(negedge clk);
    ex_is_div = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      check($sformatf("div_abort_c%0d", c), (c == 0) ? O_START : O_BUSY);
      @(negedge clk);
    end
    clrn = 1'b0;
    #1;
    check("div_abort_in_reset", O_NONE);
    @(negedge clk);
    clrn = 1'b1;
    ex_is_div = 1'b0;
    #1;
    check("div_abort_idle", O_NONE);
`ifdef HAZ_PERF_CNT_EN
    check32("abort_perf_stall", perf_stall_cnt, 32'd0);
    check32("abort_perf_flush", perf_flush_cnt, 32'd0);
`endif
    @(negedge clk);
    run_md("div_after_rst", 32, 1'b1);
`ifdef HAZ_PERF_CNT_EN
    check32("post_div_perf_stall", perf_stall_cnt, 32'd32);
`endif

    // Branch flush after the divide, then verify flush counting and the idle state
    @(negedge clk);
    pcsrc = 1'b1;
    #1;
    check("flush_after_div", O_FLUSH);
    @(negedge clk);
    pcsrc = 1'b0;
    #1;
    check("idle_after_flush", O_NONE);
`ifdef HAZ_PERF_CNT_EN
    check32("post_flush_perf_flush", perf_flush_cnt, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
